// File: rtl/bidir_bus_pkg.sv
// Shared constants and state encoding for the bidirectional buffer sequencer.
package bidir_bus_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TURN   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_FIN    = 2'd3;

  localparam logic DIR_UP   = 1'b1;  // A -> B, write
  localparam logic DIR_DOWN = 1'b0;  // B -> A, read

  localparam int unsigned TURN_CYC_DEF = 2;
  localparam int unsigned HOLD_CYC_DEF = 1;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    TURN   = ST_TURN,
    SETTLE = ST_SETTLE,
    FIN    = ST_FIN
  } state_e;

endpackage

// File: rtl/bidir_bus_timer.sv
// Loadable down-counter with a registered zero flag; stops at zero (no wrap).
module bidir_bus_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;
  logic         zero_q;

  // Next count: load wins over decrement, decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count and zero flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= (count_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Transfer sequencer driving CE/SR and A-side data of the 8-bit bidirectional buffer.
module bidir_bus_ctrl
  import bidir_bus_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TURN_CYC = TURN_CYC_DEF,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic             DIR,
  input  logic [WIDTH-1:0] WDATA,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RDATA,
  output logic             CE,
  output logic             SR,
  output logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] AOUT
);

  localparam int unsigned MAX_CYC = (TURN_CYC > HOLD_CYC) ? TURN_CYC : HOLD_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic             first_q, first_d;
  logic             ce_q, ce_d;
  logic             sr_q, sr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic             tmr_load;
  logic             tmr_dec;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  // Shared window timer for both TURN and SETTLE; reloaded on every state entry.
  bidir_bus_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Next-state, timer control and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    first_d  = first_q;
    sr_d     = sr_q;
    a_d      = a_q;
    rdata_d  = rdata_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;

    case (state_q)
      IDLE: begin
        if (REQ) begin
          dir_d    = DIR;
          sr_d     = DIR;
          a_d      = (DIR == DIR_UP) ? WDATA : '0;
          first_d  = 1'b0;
          tmr_load = 1'b1;
          // A direction change (or the first transfer) needs a CE-low gap.
          if ((DIR != sr_q) || first_q) begin
            state_d = TURN;
            tmr_val = TURN_LOAD;
          end else begin
            state_d = SETTLE;
            tmr_val = HOLD_LOAD;
          end
        end
      end
      TURN: begin
        if (tmr_zero) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_d  = FIN;
          tmr_load = 1'b1;
          if (dir_q == DIR_DOWN) begin
            rdata_d = AOUT;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      FIN: begin
        state_d  = IDLE;
        tmr_load = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ce_d   = (state_d == SETTLE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      dir_q   <= DIR_DOWN;
      first_q <= 1'b1;
      ce_q    <= 1'b0;
      sr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      first_q <= first_d;
      ce_q    <= ce_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      rdata_q <= rdata_d;
    end
  end

  assign CE    = ce_q;
  assign SR    = sr_q;
  assign A     = a_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign RDATA = rdata_q;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Bench for bidir_bus_ctrl with a behavioural 8-bit buffer beside it.
module tb_bidir_bus_ctrl;

  localparam int TURN_CYC = 2;
  localparam int HOLD_CYC = 1;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ;
  logic       DIR;
  logic [7:0] WDATA;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RDATA;
  logic       CE;
  logic       SR;
  logic [7:0] A;
  logic [7:0] AOUT;

  // Buffer model: B-side value driven toward A on reads, A forwarded to BOUT on writes.
  logic [7:0] b_reg;
  logic [7:0] bout;
  assign AOUT = (CE && !SR) ? b_reg : ~b_reg;
  assign bout = (CE && SR) ? A : 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: last direction, first-transfer flag, last read data, A hold value.
  logic       m_sr;
  logic       m_first;
  logic [7:0] m_rdata;
  logic [7:0] m_a;

  bidir_bus_ctrl #(
    .WIDTH    (8),
    .TURN_CYC (TURN_CYC),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .DIR   (DIR),
    .WDATA (WDATA),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .RDATA (RDATA),
    .CE    (CE),
    .SR    (SR),
    .A     (A),
    .AOUT  (AOUT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_sr    = 1'b0;
    m_first = 1'b1;
    m_rdata = 8'h00;
    m_a     = 8'h00;
  endtask

  // One transfer from the accept edge through the IDLE cycle after DONE.
  task automatic do_xfer(input logic dir, input logic [7:0] wd, input logic [7:0] bv,
                         input bit hold_req, input string tag);
    bit turn;
    int lat;
    turn = (dir != m_sr) || m_first;
    lat  = turn ? (TURN_CYC + HOLD_CYC + 1) : (HOLD_CYC + 1);
    REQ   = 1'b1;
    DIR   = dir;
    WDATA = wd;
    b_reg = bv;
    step();
    m_sr    = dir;
    m_first = 1'b0;
    m_a     = dir ? wd : 8'h00;
    if (!hold_req) begin
      REQ   = 1'b0;
      DIR   = 1'($urandom_range(0, 1));
      WDATA = 8'($urandom);
    end
    for (int c = 1; c <= lat; c++) begin
      bit e_ce;
      bit e_done;
      e_ce   = (c >= lat - HOLD_CYC) && (c <= lat - 1);
      e_done = (c == lat);
      if (e_done && (dir == 1'b0)) m_rdata = bv;
      n_cmp++;
      if (BUSY !== 1'b1) begin
        n_err++; $display("FAIL %s busy c%0d: got %b want 1", tag, c, BUSY);
      end
      n_cmp++;
      if (DONE !== e_done) begin
        n_err++; $display("FAIL %s done c%0d: got %b want %b", tag, c, DONE, e_done);
      end
      n_cmp++;
      if (CE !== e_ce) begin
        n_err++; $display("FAIL %s ce c%0d: got %b want %b", tag, c, CE, e_ce);
      end
      n_cmp++;
      if (SR !== dir) begin
        n_err++; $display("FAIL %s sr c%0d: got %b want %b", tag, c, SR, dir);
      end
      n_cmp++;
      if (A !== m_a) begin
        n_err++; $display("FAIL %s a c%0d: got %h want %h", tag, c, A, m_a);
      end
      n_cmp++;
      if (RDATA !== m_rdata) begin
        n_err++; $display("FAIL %s rdata c%0d: got %h want %h", tag, c, RDATA, m_rdata);
      end
      if (e_ce && dir) begin
        n_cmp++;
        if (bout !== wd) begin
          n_err++; $display("FAIL %s bout c%0d: got %h want %h", tag, c, bout, wd);
        end
      end
      step();
    end
    n_cmp++;
    if ({BUSY, DONE, CE} !== 3'b000) begin
      n_err++; $display("FAIL %s post_idle: got busy/done/ce %b want 000", tag, {BUSY, DONE, CE});
    end
  endtask

  task automatic idle_cycles(input int n);
    REQ = 1'b0;
    for (int i = 0; i < n; i++) begin
      DIR   = 1'($urandom_range(0, 1));
      WDATA = 8'($urandom);
      step();
      n_cmp++;
      if ({BUSY, DONE, CE} !== 3'b000) begin
        n_err++; $display("FAIL idle ctl: got busy/done/ce %b want 000", {BUSY, DONE, CE});
      end
      n_cmp++;
      if ({SR, A, RDATA} !== {m_sr, m_a, m_rdata}) begin
        n_err++; $display("FAIL idle hold: got sr %b a %h rd %h want sr %b a %h rd %h",
                          SR, A, RDATA, m_sr, m_a, m_rdata);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = 1'b0; DIR = 1'b0; WDATA = 8'h00; b_reg = 8'h00;
    step();
    step();
    model_reset();
    n_cmp++;
    if ({CE, SR, BUSY, DONE} !== 4'b0000) begin
      n_err++; $display("FAIL reset ctl: got ce/sr/busy/done %b want 0000", {CE, SR, BUSY, DONE});
    end
    n_cmp++;
    if (A !== 8'h00) begin
      n_err++; $display("FAIL reset a: got %h want 00", A);
    end
    n_cmp++;
    if (RDATA !== 8'h00) begin
      n_err++; $display("FAIL reset rdata: got %h want 00", RDATA);
    end
    RST = 1'b0;
    step();
  endtask

  task automatic test_first_write();
    do_xfer(1'b1, 8'hAA, 8'h11, 1'b0, "first_wr");
  endtask

  task automatic test_follow_write();
    do_xfer(1'b1, 8'h55, 8'h22, 1'b0, "follow_wr");
  endtask

  task automatic test_read_turn();
    do_xfer(1'b0, 8'h99, 8'h3C, 1'b0, "read_turn");
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b1, 8'h0F, 8'h00, 1'b0, "b2b_pre");
    do_xfer(1'b0, 8'h12, 8'hC3, 1'b1, "b2b_1");
    do_xfer(1'b0, 8'h34, 8'h5A, 1'b1, "b2b_2");
    REQ = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_reset_in_turn();
    REQ = 1'b1; DIR = 1'b1; WDATA = 8'hE7;
    step();
    REQ = 1'b0;
    n_cmp++;
    if ({BUSY, CE, SR} !== 3'b101) begin
      n_err++; $display("FAIL rst_turn pre: got busy/ce/sr %b want 101", {BUSY, CE, SR});
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    model_reset();
    n_cmp++;
    if ({CE, SR, BUSY, DONE} !== 4'b0000) begin
      n_err++; $display("FAIL rst_turn post: got ce/sr/busy/done %b want 0000", {CE, SR, BUSY, DONE});
    end
    n_cmp++;
    if ({A, RDATA} !== 16'h0000) begin
      n_err++; $display("FAIL rst_turn data: got a %h rd %h want 00 00", A, RDATA);
    end
    do_xfer(1'b0, 8'h00, 8'hB4, 1'b0, "rst_first_rd");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      idle_cycles($urandom_range(0, 3));
      do_xfer(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b0, "rand");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_write();
    test_follow_write();
    test_read_turn();
    test_back_to_back();
    test_reset_in_turn();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
